de2_115_qsys_key_pio: RTL

DE2_115_QSYS_KEY_PIO -- requirements
Module: de2_115_qsys_key_pio

---
 rtl/key_pio_pkg.sv | 23 ++
 rtl/key_pio_debounce.sv | 66 ++++++
 rtl/de2_115_qsys_key_pio.sv | 104 ++++++++++
 3 files changed

// File: rtl/key_pio_pkg.sv
// Shared constants for the DE2-115 key PIO: register offsets and the default debounce length.
// KEY_PIO_DEBOUNCE_EN selects the per-key debounce counters.
package key_pio_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_RESERVED = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

`ifdef KEY_PIO_DEBOUNCE_EN
   localparam bit DEBOUNCE_EN = 1'b1;
`else
   localparam bit DEBOUNCE_EN = 1'b0;
`endif

   // Cycles after reset release until deb reflects the real key levels
   function automatic int settleCycles(input int debounceCycles);
      return DEBOUNCE_EN ? debounceCycles + 3 : 3;
   endfunction

endpackage

// File: rtl/key_pio_debounce.sv
// One key bit: two-flop synchronizer, plus a stability counter when KEY_PIO_DEBOUNCE_EN is defined.
module key_pio_debounce
   import key_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic key_i,
   output logic deb_o
);

   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef KEY_PIO_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             debBit_q;
   logic             debBit_d;

   // The counter only runs while the synchronized level disagrees with the accepted one
   always_comb begin
      count_d  = count_q;
      debBit_d = debBit_q;
      if (sync2_q == debBit_q) begin
         count_d = '0;
      end else if (count_q == CNT_LAST) begin
         debBit_d = sync2_q;
         count_d  = '0;
      end else begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= '0;
         debBit_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         debBit_q <= debBit_d;
      end
   end

   assign deb_o = debBit_q;
`else
   localparam int unusedDebounceCycles = DEBOUNCE_CYCLES;

   assign deb_o = sync2_q;
`endif

endmodule

// File: rtl/de2_115_qsys_key_pio.sv
// Avalon-MM key PIO: debounced key levels, falling-edge capture with W1C clear, masked level IRQ.
// KEY_PIO_DEBOUNCE_EN enables the per-key debounce counters.
module de2_115_qsys_key_pio
   import key_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int SETTLE   = settleCycles(DEBOUNCE_CYCLES);
   localparam int SETTLE_W = $clog2(SETTLE + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE);

   logic [WIDTH-1:0]    deb;
   logic [WIDTH-1:0]    debPrev_q;
   logic [WIDTH-1:0]    irqMask_q;
   logic [WIDTH-1:0]    irqMask_d;
   logic [WIDTH-1:0]    edgeCap_q;
   logic [WIDTH-1:0]    edgeCap_d;
   logic [WIDTH-1:0]    armed_q;
   logic [WIDTH-1:0]    armed_d;
   logic [SETTLE_W-1:0] settleCnt_q;
   logic [SETTLE_W-1:0] settleCnt_d;
   logic [WIDTH-1:0]    fall;
   logic [WIDTH-1:0]    clearMask;
   logic                wrEn;
   logic                settled;

   for (genvar i = 0; i < WIDTH; i++) begin : gKey
      key_pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uKey (
         .clk   (clk),
         .reset (reset),
         .key_i (in_port[i]),
         .deb_o (deb[i])
      );
   end

   if (WIDTH < 32) begin : gUnusedWrite
      logic unusedWriteBits;
      assign unusedWriteBits = ^writedata[31:WIDTH];
   end

   assign wrEn    = chipselect & ~write_n;
   assign settled = (settleCnt_q == SETTLE_LAST);

   // A key held low across reset release only arms once it has been seen released
   assign fall = debPrev_q & ~deb & armed_q;

   always_comb begin
      irqMask_d   = irqMask_q;
      clearMask   = '0;
      if (wrEn && (address == ADDR_IRQMASK)) begin
         irqMask_d = writedata[WIDTH-1:0];
      end
      if (wrEn && (address == ADDR_EDGECAP)) begin
         clearMask = writedata[WIDTH-1:0];
      end
      edgeCap_d   = (edgeCap_q & ~clearMask) | fall;
      armed_d     = settled ? (armed_q | deb) : armed_q;
      settleCnt_d = settled ? settleCnt_q : settleCnt_q + SETTLE_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         debPrev_q   <= '1;
         irqMask_q   <= '0;
         edgeCap_q   <= '0;
         armed_q     <= '0;
         settleCnt_q <= '0;
      end else begin
         debPrev_q   <= deb;
         irqMask_q   <= irqMask_d;
         edgeCap_q   <= edgeCap_d;
         armed_q     <= armed_d;
         settleCnt_q <= settleCnt_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:     readdata[WIDTH-1:0] = deb;
         ADDR_RESERVED: readdata = '0;
         ADDR_IRQMASK:  readdata[WIDTH-1:0] = irqMask_q;
         ADDR_EDGECAP:  readdata[WIDTH-1:0] = edgeCap_q;
         default:       readdata = '0;
      endcase
   end

   assign irq = |(edgeCap_q & irqMask_q);

endmodule
